// File: rtl/enable_map_loader.sv
// Boot/reconfiguration sequencer: debounces the config switches, reads the selected
// 64-entry enable map from SPI flash and writes it into the enable table.
module enable_map_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [23:0] TABLE_BASE      = 24'h000000
) (
  input  logic       fpga_clk,
  input  logic       rst_n,
  input  logic [3:0] configuration,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       tbl_we,
  output logic [5:0] tbl_addr,
  output logic [1:0] tbl_data,
  output logic [3:0] config_byte,
  output logic       ready,
  output logic       cpu_reset_n
);

  localparam logic [15:0] CntMax  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  ReadCmd = 8'h03;

  typedef enum logic [2:0] {StDebounce, StCmd, StData, StDone, StWatch} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cfg_meta_q, cfg_sync_q, cfg_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  bit_q, bit_d;
  logic [31:0] shift_q, shift_d;
  logic        rx_q, rx_d;
  logic        cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d, we_q, we_d;
  logic [5:0]  addr_q, addr_d;
  logic [1:0]  data_q, data_d;
  logic [3:0]  cfg_q, cfg_d;
  logic        ready_q, ready_d, cpu_rst_n_q, cpu_rst_n_d;
  logic        stable, cnt_done, start_load;
  logic [23:0] load_addr;

  always_comb begin
    stable      = (cfg_sync_q == cfg_prev_q);
    cnt_done    = stable && (cnt_q == CntMax);
    load_addr   = TABLE_BASE + {14'd0, cfg_sync_q, 6'd0};
    start_load  = 1'b0;
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cfg_d       = cfg_q;
    ready_d     = ready_q;
    cpu_rst_n_d = cpu_rst_n_q;

    // Stability is tracked in every state so a change made during a load is already
    // qualified by the time WATCH looks at it.
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    unique case (state_q)
      StDebounce: start_load = cnt_done;
      StCmd: begin
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          sck_d   = 1'b0;
          bit_d   = bit_q + 9'd1;
          shift_d = {shift_q[30:0], 1'b0};
          mosi_d  = shift_q[30];
          if (bit_q == 9'd31) begin
            state_d = StData;
            mosi_d  = 1'b0;
            bit_d   = '0;
          end
        end
      end
      StData: begin
        if (!sck_q) begin
          // miso is sampled on the edge that raises sck
          sck_d = 1'b1;
          rx_d  = spi_miso;
          if (bit_q[2:0] == 3'd7) begin
            we_d   = 1'b1;
            addr_d = bit_q[8:3];
            data_d = {rx_q, spi_miso};
          end
        end else begin
          sck_d = 1'b0;
          bit_d = bit_q + 9'd1;
          if (bit_q == 9'd511) begin
            cs_n_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        ready_d     = 1'b1;
        cpu_rst_n_d = 1'b1;
        state_d     = StWatch;
      end
      StWatch: start_load = cnt_done && (cfg_sync_q != cfg_q);
      default: state_d = StDebounce;
    endcase

    if (start_load) begin
      cfg_d       = cfg_sync_q;
      shift_d     = {ReadCmd, load_addr};
      mosi_d      = ReadCmd[7];
      cs_n_d      = 1'b0;
      sck_d       = 1'b0;
      bit_d       = '0;
      ready_d     = 1'b0;
      cpu_rst_n_d = 1'b0;
      state_d     = StCmd;
    end
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDebounce;
      cfg_meta_q  <= '0;
      cfg_sync_q  <= '0;
      cfg_prev_q  <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cfg_q       <= '0;
      ready_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_meta_q  <= configuration;
      cfg_sync_q  <= cfg_meta_q;
      cfg_prev_q  <= cfg_sync_q;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cfg_q       <= cfg_d;
      ready_q     <= ready_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign spi_cs_n    = cs_n_q;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;
  assign tbl_we      = we_q;
  assign tbl_addr    = addr_q;
  assign tbl_data    = data_q;
  assign config_byte = cfg_q;
  assign ready       = ready_q;
  assign cpu_reset_n = cpu_rst_n_q;

endmodule

// File: doc/enable_map_loader.md
# enable_map_loader

Boot-time and reconfiguration sequencer for the ROMulator RAM/bus enable map. The block debounces the 4-bit configuration switches and latches the selected configuration. It then reads that configuration's 64-entry enable map from SPI flash and writes it into the enable table. The CPU is held in reset and the enable logic is held not-ready until the table is valid. It sits between the config switches and SPI flash on one side, and the enable-table write port and CPU reset line on the other.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a configuration value is accepted (2..65535).
- TABLE_BASE, 24'h000000: flash byte address of the entry-0 table; config N's table starts at TABLE_BASE + N*64.
- fpga_clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- configuration  in  4  raw config switch inputs, asynchronous; double-registered internally before use.
- spi_miso  in  1  flash serial data out.
- spi_cs_n  out  1  flash chip select, active low.
- spi_sck  out  1  SPI clock, mode 0, fpga_clk/2.
- spi_mosi  out  1  flash serial data in, MSB first.
- tbl_we  out  1  one-cycle enable-table write strobe.
- tbl_addr  out  6  entry index 0..63 (rwbar, address[11], address[15:12] order).
- tbl_data  out  2  {cs_ram_en, cs_bus_en} for the entry.
- config_byte  out  4  accepted configuration; selects the live table.
- ready  out  1  table valid; enable outputs may be gated with it.
- cpu_reset_n  out  1  active-low reset to the target CPU.

## Operation
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, tbl_we=0, tbl_addr=0, tbl_data=0, config_byte=0, ready=0, cpu_reset_n=0. The state machine enters DEBOUNCE with the counter at 0.
- States: DEBOUNCE, CMD, DATA, DONE, WATCH.
- DEBOUNCE: compare the synced configuration with the previous cycle's value. On any difference, clear the counter. Otherwise increment. When the count reaches DEBOUNCE_CYCLES, latch config_byte and go to CMD.
- CMD: assert spi_cs_n=0 and shift 32 bits: 8'h03, then the 24-bit address TABLE_BASE + {config_byte,6'b0}. Address arithmetic is 24-bit and wraps modulo 2^24.
- DATA: shift in 64 bytes, MSB first. After each byte's 8th bit is sampled, pulse tbl_we for exactly one cycle, with tbl_addr = byte index and tbl_data = byte[1:0]. Byte bits [7:2] are ignored.
- After byte 63 is written, set spi_cs_n=1 and go to DONE.
- DONE: assert ready=1 and cpu_reset_n=1, then go to WATCH.
- WATCH: monitor the synced configuration.
  - A value different from config_byte that stays stable for DEBOUNCE_CYCLES triggers a reload: ready=0 and cpu_reset_n=0 on the same cycle, latch the new config_byte, go to CMD.
  - A change that reverts before reaching the count does nothing.
- Configuration changes during CMD/DATA are ignored. The load completes with the latched value, and WATCH then detects the difference.
- Asserting rst_n mid-transfer immediately forces all reset values, including spi_cs_n=1, and aborts the read.

## Timing
- SPI bit period is 2 fpga_clk cycles:
  - Phase 0: spi_sck=0, spi_mosi updated.
  - Phase 1: spi_sck=1, spi_miso sampled on the same fpga_clk edge that drives spi_sck high.
- spi_cs_n falls on the cycle after the debounce count completes. The first spi_sck rise is one cycle later.
- CMD lasts 64 cycles. DATA lasts 1024 cycles. tbl_we pulses are 16 cycles apart. The first pulse comes 16 cycles after DATA starts; the last comes at the end of DATA.
- spi_cs_n rises the cycle after the final tbl_we. ready and cpu_reset_n rise one cycle after that.
- Total latency from debounce acceptance to ready is 1091 cycles ±1. The bench checks the exact value as implemented and holds it constant.
- spi_mosi is 0 throughout DATA. spi_sck idles low whenever spi_cs_n=1.
- The configuration synchronizer adds 2 cycles before debounce counting.

## Test plan
- Config=4'h5 held from reset, DEBOUNCE_CYCLES=16, TABLE_BASE=0. Required: MOSI carries 03 00 01 40; flash returns bytes i^8'hFC; 64 tbl_we pulses with tbl_addr 0..63, tbl_data=(i^0xFC)&3; then ready=1, cpu_reset_n=1, config_byte=5.
- Config toggles 5/6 every 10 cycles for 200 cycles, then holds 6. Required: spi_cs_n stays 1 until 6 has been stable for 16 cycles; command address is 0x000180.
- After ready, config changes 5→9 and is held. Required: ready and cpu_reset_n fall together after 16+2 cycles; reload from 0x000240; ready rises again; config_byte=9.
- Config changes to 2 at data byte 30. Required: the load completes with config 5. Then ready=1 for one cycle, followed by a reload from 0x000080.
- rst_n pulsed low at data byte 40. Required: spi_cs_n=1, ready=0, cpu_reset_n=0, tbl_we=0 immediately (asynchronously). After release, a full reload starts from debounce.
- TABLE_BASE=24'hFFFFC0 with config=1. Required: the address wraps to 24'h000000.
